// File: rtl/gpu_write_buffer_if.sv
// Pixel-write, clear-request and SRAM-write signals of the GPU write buffer.
// The buffer sits on the slave side. The rasterizer/SRAM-side driver sits on the master side.
interface gpu_write_buffer_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int LVL_W  = 5
);
    logic              I_VIDEO_ON;
    logic              I_PIX_VALID;
    logic              O_PIX_READY;
    logic [ADDR_W-1:0] I_PIX_ADDR;
    logic [DATA_W-1:0] I_PIX_DATA;
    logic              I_CLEAR;
    logic [DATA_W-1:0] I_CLEAR_DATA;
    logic              O_BUSY;
    logic [LVL_W-1:0]  O_LEVEL;
    logic [7:0]        O_DROP_CNT;
    logic [ADDR_W-1:0] O_SRAM_ADDR;
    logic [DATA_W-1:0] O_SRAM_DATA;
    logic              O_SRAM_WRITE;
    logic              O_SRAM_READ;

    modport master (
        output I_VIDEO_ON, I_PIX_VALID, I_PIX_ADDR, I_PIX_DATA, I_CLEAR, I_CLEAR_DATA,
        input  O_PIX_READY, O_BUSY, O_LEVEL, O_DROP_CNT,
               O_SRAM_ADDR, O_SRAM_DATA, O_SRAM_WRITE, O_SRAM_READ
    );

    modport slave (
        input  I_VIDEO_ON, I_PIX_VALID, I_PIX_ADDR, I_PIX_DATA, I_CLEAR, I_CLEAR_DATA,
        output O_PIX_READY, O_BUSY, O_LEVEL, O_DROP_CNT,
               O_SRAM_ADDR, O_SRAM_DATA, O_SRAM_WRITE, O_SRAM_READ
    );
endinterface

// File: rtl/gpu_write_buffer.sv
// Pixel write buffer between the rasterizer and the frame-buffer SRAM.
// Queued pixels, and the full-screen clear sweep, reach SRAM only while the display is blanking.
module gpu_write_buffer #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int FB_WORDS = 256000
) (
    input  logic I_CLK,
    input  logic I_RST,
    gpu_write_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    localparam logic [0:0] ST_DRAIN = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [ADDR_W:0]   FB_LIMIT  = (ADDR_W + 1)'(FB_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [LVL_W-1:0]  wr_ptr;
    logic [LVL_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [0:0]        state;
    logic              clear_pending;
    logic              sweep_last;
    logic [ADDR_W-1:0] sweep_cnt;
    logic [DATA_W-1:0] clear_colour;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_data;
    logic              sram_write;
    logic [7:0]        drop_cnt;

    logic              full;
    logic              empty;
    logic              pix_ready;
    logic              xfer;
    logic              in_range;
    logic              push;
    logic              pop;
    logic              drop;
    logic              clear_accept;
    logic [ENT_W-1:0]  head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    assign pix_ready    = !full && !clear_pending && (state == ST_DRAIN);
    assign xfer         = bus.I_PIX_VALID && pix_ready;
    assign in_range     = ({1'b0, bus.I_PIX_ADDR} < FB_LIMIT);
    assign push         = xfer && in_range;
    assign drop         = xfer && !in_range;
    assign pop          = (state == ST_DRAIN) && !bus.I_VIDEO_ON && !empty;
    assign clear_accept = bus.I_CLEAR && (state != ST_CLEAR);

    always_ff @(posedge I_CLK) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= {bus.I_PIX_ADDR, bus.I_PIX_DATA};
        end
    end

    always_ff @(posedge I_CLK) begin
        if (clear_accept) begin
            clear_colour <= bus.I_CLEAR_DATA;
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            state         <= ST_DRAIN;
            clear_pending <= 1'b0;
            sweep_last    <= 1'b0;
            sweep_cnt     <= '0;
            sram_addr     <= '0;
            sram_data     <= '0;
            sram_write    <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + LVL_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LVL_W'(1);
            end
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
            if (clear_accept) begin
                clear_pending <= 1'b1;
            end

            case (state)
                ST_DRAIN: begin
                    if (pop) begin
                        sram_addr  <= head[ENT_W-1:DATA_W];
                        sram_data  <= head[DATA_W-1:0];
                        sram_write <= 1'b1;
                    end else begin
                        sram_write <= 1'b0;
                    end
                    // The clear starts only after every previously queued pixel has landed.
                    if (clear_pending && empty) begin
                        state      <= ST_CLEAR;
                        sweep_cnt  <= '0;
                        sweep_last <= 1'b0;
                        if (!clear_accept) begin
                            clear_pending <= 1'b0;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (sweep_last) begin
                        state      <= ST_DRAIN;
                        sweep_last <= 1'b0;
                        sram_write <= 1'b0;
                    end else if (!bus.I_VIDEO_ON) begin
                        sram_addr  <= sweep_cnt;
                        sram_data  <= clear_colour;
                        sram_write <= 1'b1;
                        if (sweep_cnt == LAST_ADDR) begin
                            sweep_last <= 1'b1;
                        end else begin
                            sweep_cnt <= sweep_cnt + ADDR_W'(1);
                        end
                    end else begin
                        sram_write <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.O_PIX_READY  = pix_ready;
    assign bus.O_BUSY       = !empty || clear_pending || (state == ST_CLEAR);
    assign bus.O_LEVEL      = level;
    assign bus.O_DROP_CNT   = drop_cnt;
    assign bus.O_SRAM_ADDR  = sram_addr;
    assign bus.O_SRAM_DATA  = sram_data;
    assign bus.O_SRAM_WRITE = sram_write;
    assign bus.O_SRAM_READ  = 1'b0;
endmodule
